// File: rtl/vec_mem_responder_if.sv
// Request/response bus between the pipeline memory stage and the vector responder.
interface vec_mem_responder_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 18,
    parameter int unsigned LANES  = 3
);
    logic                      req_valid;
    logic                      req_we;
    logic [ADDR_W-1:0]         req_addr;
    logic [LANES*DATA_W-1:0]   req_wdata;
    logic                      stall;
    logic                      rsp_valid;
    logic [LANES*DATA_W-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  stall, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output stall, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/vec_mem_responder.sv
// Serialises one LANES-wide vector load/store into single-lane memory cycles,
// stalling the pipeline until the access completes.
module vec_mem_responder #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 18,
    parameter int unsigned LANES  = 3
) (
    input  logic               CLK,
    input  logic               RST,
    vec_mem_responder_if.slave bus,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RDRAIN,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [LANE_W-1:0]           r_lane;
    logic [ADDR_W-1:0]           r_base;
    logic [LANES-1:0][DATA_W-1:0] r_wdata;
    logic [LANES-1:0][DATA_W-1:0] r_rbuf;
    logic [LANES-1:0][DATA_W-1:0] w_rsp;
    logic                        r_mem_en;
    logic                        r_mem_we;
    logic [ADDR_W-1:0]           r_mem_addr;
    logic [DATA_W-1:0]           r_mem_wdata;
    logic                        r_rsp_valid;
    logic [LANES*DATA_W-1:0]     r_rsp_rdata;

    logic                        w_accept;
    logic                        w_stall;
    logic                        w_issue;
    logic                        w_last;
    logic [LANE_W-1:0]           w_lane_nxt;
    logic [ADDR_W-1:0]           w_addr_nxt;

    assign w_issue    = (r_state == S_WRITE) || (r_state == S_READ);
    assign w_last     = (r_lane == LAST_LANE);
    assign w_lane_nxt = r_lane + LANE_W'(1);
    assign w_addr_nxt = r_base + ADDR_W'(r_lane) + ADDR_W'(1);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next state, acceptance and the combinational stall
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_stall  = 1'b1;
                    w_next   = bus.req_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                w_stall = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_READ: begin
                w_stall = 1'b1;
                if (w_last) w_next = S_RDRAIN;
            end
            S_RDRAIN: begin
                w_stall = 1'b1;
                w_next  = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Last lane comes straight from the memory; earlier lanes from the capture buffer
    always_comb begin
        w_rsp            = r_rbuf;
        w_rsp[LANES-1]   = mem_rdata;
    end

    // Request latch, memory port, read capture and response registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_lane      <= '0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_rbuf      <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_base     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_lane     <= '0;
                r_mem_en   <= 1'b1;
                r_mem_we   <= bus.req_we;
                r_mem_addr <= bus.req_addr;
                if (bus.req_we) r_mem_wdata <= bus.req_wdata[DATA_W-1:0];
            end else if (w_issue) begin
                if (!w_last) begin
                    r_lane     <= w_lane_nxt;
                    r_mem_en   <= 1'b1;
                    r_mem_we   <= (r_state == S_WRITE);
                    r_mem_addr <= w_addr_nxt;
                    if (r_state == S_WRITE) r_mem_wdata <= r_wdata[w_lane_nxt];
                end
                // mem_rdata now holds the lane issued on the previous cycle
                if ((r_state == S_READ) && (r_lane != '0)) begin
                    r_rbuf[r_lane - LANE_W'(1)] <= mem_rdata;
                end
            end else if (r_state == S_RDRAIN) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_rsp;
            end
        end
    end

    assign mem_en        = r_mem_en;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign bus.stall     = w_stall;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule
